// File: rtl/iiitb_usr_pkg.sv
// Shared encodings for the universal-shift-register sequencer: FSM states,
// command op codes and shift-register mode codes.
package iiitb_usr_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StLoad  = 2'b01,
      StRot   = 2'b10,
      StCheck = 2'b11
   } state_t;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_ROL  = 2'b10;
   localparam logic [1:0] OP_ROR  = 2'b11;

   // Mode codes as the downstream shift register decodes them.
   localparam logic [1:0] CTRL_HOLD = 2'b00;
   localparam logic [1:0] CTRL_ROL  = 2'b10;
   localparam logic [1:0] CTRL_ROR  = 2'b01;
   localparam logic [1:0] CTRL_LOAD = 2'b11;

endpackage

// File: rtl/iiitb_usr_seq.sv
// Command sequencer driving a universal shift register, with a shadow copy
// of the register used to check the fed-back q_in when each command ends.
module iiitb_usr_seq
   import iiitb_usr_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNTW  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNTW-1:0]  cmd_count,
   output logic [1:0]       ctrl,
   output logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] q_in,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] exp_q
);

   state_t           state_q, state_d;
   logic             rot_right_q, rot_right_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             accept;

   assign cmd_ready = (state_q == StIdle);
   assign accept    = cmd_valid & cmd_ready;

   always_comb begin
      state_d     = state_q;
      rot_right_d = rot_right_q;
      cnt_d       = cnt_q;
      d_d         = d_q;
      shadow_d    = shadow_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               unique case (cmd_op)
                  OP_LOAD: begin
                     d_d     = cmd_data;
                     state_d = StLoad;
                  end
                  OP_ROL, OP_ROR: begin
                     rot_right_d = (cmd_op == OP_ROR);
                     cnt_d       = cmd_count;
                     state_d     = (cmd_count != '0) ? StRot : StCheck;
                  end
                  default: state_d = StCheck;
               endcase
            end
         end
         StLoad: begin
            shadow_d = d_q;
            state_d  = StCheck;
         end
         StRot: begin
            // Shadow follows the shift register step for step.
            shadow_d = rot_right_q ? {shadow_q[0], shadow_q[WIDTH-1:1]}
                                   : {shadow_q[WIDTH-2:0], shadow_q[WIDTH-1]};
            cnt_d    = cnt_q - CNTW'(1);
            if (cnt_q <= CNTW'(1)) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         rot_right_q <= 1'b0;
         cnt_q       <= '0;
         d_q         <= '0;
         shadow_q    <= '0;
      end else begin
         state_q     <= state_d;
         rot_right_q <= rot_right_d;
         cnt_q       <= cnt_d;
         d_q         <= d_d;
         shadow_q    <= shadow_d;
      end
   end

   // Outputs decode registered state only; cmd_* never reach them directly.
   always_comb begin
      ctrl = CTRL_HOLD;
      unique case (state_q)
         StLoad:  ctrl = CTRL_LOAD;
         StRot:   ctrl = rot_right_q ? CTRL_ROR : CTRL_ROL;
         default: ctrl = CTRL_HOLD;
      endcase
   end

   assign d     = d_q;
   assign exp_q = shadow_q;
   assign done  = (state_q == StCheck);
   assign err   = done & (q_in != shadow_q);

endmodule
